// File: rtl/dt_slim_hit_scan.sv
// Player/slime collision scanner: snapshots positions on frame_tick and tests one slime per cycle.
// The scanner tracks lives, runs an invincibility cooldown after each hit, and latches game over.
module dt_slim_hit_scan #(
    parameter int N_SLIM  = 4,
    parameter int HALF_W  = 55,
    parameter int HALF_H  = 38,
    parameter int INV_CYC = 25000000,
    parameter int LIVES   = 3,
    localparam int ID_W   = (N_SLIM > 1) ? $clog2(N_SLIM) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  frame_tick,
    input  logic [9:0]            x_blue,
    input  logic [8:0]            y_blue,
    input  logic [10*N_SLIM-1:0]  x_slim,
    input  logic [9*N_SLIM-1:0]   y_slim,
    input  logic [N_SLIM-1:0]     isfrozen,
    output logic                  broken,
    output logic [ID_W-1:0]       hit_id,
    output logic [3:0]            lives,
    output logic                  invincible,
    output logic                  game_over
);

    localparam int CNT_W = $clog2(INV_CYC + 1);

    typedef enum logic [2:0] {IDLE, SCAN, HIT, COOL, DEAD} state_t;

    state_t            state;
    logic [ID_W-1:0]   idx;
    logic [CNT_W-1:0]  cnt;

    logic [9:0]        bx_p0;
    logic [8:0]        by_p0;
    logic [9:0]        xs_p0 [N_SLIM];
    logic [8:0]        ys_p0 [N_SLIM];
    logic [N_SLIM-1:0] frz_p0;
    logic              hit_now;

    // Overlap along one axis, widened so that a+h and b+h can never wrap at screen edges.
    function automatic logic overlap(input logic [9:0] a, input logic [9:0] b, input int h);
        logic [11:0] aw;
        logic [11:0] bw;
        logic [11:0] hw;
        aw = {2'b00, a};
        bw = {2'b00, b};
        hw = 12'(h);
        return ((aw + hw) > bw) && ((bw + hw) > aw);
    endfunction

    // Stage p0: frame snapshot, the only source the scan ever looks at.
    always_ff @(posedge clk) begin
        if (state == IDLE && frame_tick) begin
            bx_p0  <= x_blue;
            by_p0  <= y_blue;
            frz_p0 <= isfrozen;
            for (int k = 0; k < N_SLIM; k++) begin
                xs_p0[k] <= x_slim[10*k +: 10];
                ys_p0[k] <= y_slim[9*k +: 9];
            end
        end
    end

    always_comb begin
        hit_now = !frz_p0[idx]
                  && overlap(bx_p0, xs_p0[idx], HALF_W)
                  && overlap({1'b0, by_p0}, {1'b0, ys_p0[idx]}, HALF_H);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            cnt        <= '0;
            broken     <= 1'b0;
            hit_id     <= '0;
            lives      <= 4'(LIVES);
            invincible <= 1'b0;
            game_over  <= 1'b0;
        end else begin
            broken <= 1'b0;
            case (state)
                IDLE: begin
                    if (frame_tick) begin
                        idx   <= '0;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (hit_now) begin
                        broken <= 1'b1;
                        hit_id <= idx;
                        lives  <= (lives != 4'd0) ? lives - 4'd1 : 4'd0;
                        state  <= HIT;
                    end else if (idx == ID_W'(N_SLIM - 1)) begin
                        state <= IDLE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                HIT: begin
                    if (lives == 4'd0) begin
                        game_over <= 1'b1;
                        state     <= DEAD;
                    end else begin
                        invincible <= 1'b1;
                        cnt        <= '0;
                        state      <= COOL;
                    end
                end
                COOL: begin
                    // invincible was raised on entry, so counting 0..INV_CYC-1 gives INV_CYC cycles.
                    if (cnt == CNT_W'(INV_CYC - 1)) begin
                        invincible <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DEAD: begin
                    game_over  <= 1'b1;
                    invincible <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dt_slim_hit_scan.sv
// Directed bench for dt_slim_hit_scan: a reference collision model queues expected hits,
// and a negedge monitor pops and compares them whenever broken pulses.
module tb_dt_slim_hit_scan;

    localparam int N       = 4;
    localparam int HALF_W  = 55;
    localparam int HALF_H  = 38;
    localparam int INV_CYC = 8;
    localparam int LIVES   = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            frame_tick;
    logic [9:0]      x_blue;
    logic [8:0]      y_blue;
    logic [10*N-1:0] x_slim;
    logic [9*N-1:0]  y_slim;
    logic [N-1:0]    isfrozen;
    logic            broken;
    logic [1:0]      hit_id;
    logic [3:0]      lives;
    logic            invincible;
    logic            game_over;

    dt_slim_hit_scan #(
        .N_SLIM(N), .HALF_W(HALF_W), .HALF_H(HALF_H), .INV_CYC(INV_CYC), .LIVES(LIVES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
        .x_blue(x_blue), .y_blue(y_blue), .x_slim(x_slim), .y_slim(y_slim),
        .isfrozen(isfrozen), .broken(broken), .hit_id(hit_id), .lives(lives),
        .invincible(invincible), .game_over(game_over)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int id;
        int lv;
        int at;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;
    int   bx, by;
    int   sx[N];
    int   sy[N];
    logic [N-1:0] frz;
    int   lives_m;
    int   exp_inv;
    int   last_t;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic apply();
        x_blue   = 10'(bx);
        y_blue   = 9'(by);
        isfrozen = frz;
        for (int k = 0; k < N; k++) begin
            x_slim[10*k +: 10] = 10'(sx[k]);
            y_slim[9*k +: 9]   = 9'(sy[k]);
        end
    endtask

    task automatic place(input int px, input int py);
        bx  = px;
        by  = py;
        frz = '0;
        for (int k = 0; k < N; k++) begin
            sx[k] = 600;
            sy[k] = 400;
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && broken !== 1'b0) begin
            if (q.size() == 0) begin
                check("unexpected_broken", 32'd1, 32'd0);
            end else begin
                mon_e = q.pop_front();
                check("broken_cycle", cyc, mon_e.at);
                check("hit_id", 32'(hit_id), mon_e.id);
                check("lives_at_hit", 32'(lives), mon_e.lv);
            end
        end
    end

    // Issue one frame from IDLE; the model decides which slime (if any) should hit.
    task automatic do_frame();
        int   k_hit;
        exp_t e;
        k_hit = -1;
        @(posedge clk);
        #1;
        apply();
        if (lives_m > 0) begin
            for (int k = N - 1; k >= 0; k--) begin
                if (!frz[k] && iabs(bx - sx[k]) < HALF_W && iabs(by - sy[k]) < HALF_H)
                    k_hit = k;
            end
        end
        last_t  = cyc;
        exp_inv = 0;
        if (k_hit >= 0) begin
            lives_m--;
            e.id = k_hit;
            e.lv = lives_m;
            e.at = cyc + 2 + k_hit;
            q.push_back(e);
            exp_inv = (lives_m > 0) ? INV_CYC : 0;
        end
        frame_tick = 1'b1;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
    endtask

    task automatic raw_tick();
        @(posedge clk);
        #1;
        frame_tick = 1'b1;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
    endtask

    task automatic settle(input bit check_inv);
        int n;
        n = 0;
        repeat (INV_CYC + N + 6) begin
            @(negedge clk);
            if (invincible === 1'b1) n++;
        end
        if (check_inv) check("inv_cycles", n, exp_inv);
        check("queue_drained", q.size(), 0);
        check("lives_after", 32'(lives), lives_m);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n   = 1'b0;
        lives_m = LIVES;
        q.delete();
        repeat (3) @(posedge clk);
        #1;
        check("rst_broken", 32'(broken), 0);
        check("rst_hit_id", 32'(hit_id), 0);
        check("rst_lives", 32'(lives), LIVES);
        check("rst_invincible", 32'(invincible), 0);
        check("rst_game_over", 32'(game_over), 0);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n      = 1'b0;
        frame_tick = 1'b0;
        lives_m    = LIVES;
        place(100, 100);
        apply();
        do_reset();

        // Single hit on slime 2; the snapshot must ignore the move made during the scan.
        place(100, 100);
        sx[2] = 150; sy[2] = 130;
        do_frame();
        sx[2] = 600; sy[2] = 400;
        apply();
        settle(1);

        // Horizontal boundary.
        place(100, 100); sx[0] = 155;  sy[0] = 100; do_frame(); settle(1);
        place(100, 100); sx[0] = 154;  sy[0] = 100; do_frame(); settle(1);
        do_reset();

        // Vertical boundary and screen edges.
        place(100, 100); sx[1] = 100; sy[1] = 138; do_frame(); settle(1);
        place(0, 0);     sx[0] = 10;  sy[0] = 5;   do_frame(); settle(1);
        place(5, 5);     sx[0] = 639; sy[0] = 479; do_frame(); settle(1);
        do_reset();

        // Priority with a frozen low-index slime, then everything overlapping frozen.
        place(100, 100);
        sx[0] = 100; sy[0] = 100; frz[0] = 1'b1;
        sx[1] = 110; sy[1] = 110;
        sx[3] = 90;  sy[3] = 90;
        do_frame(); settle(1);
        frz = 4'b1011;
        do_frame(); settle(1);
        do_reset();

        // Exhaustion, with requests during cooldown and after death ignored.
        place(100, 100); sx[0] = 100; sy[0] = 100;
        do_frame();
        repeat (3) @(posedge clk);
        raw_tick();
        settle(0);
        do_frame(); settle(1);
        do_frame(); settle(1);
        check("game_over_set", 32'(game_over), 1);
        check("dead_invincible", 32'(invincible), 0);
        raw_tick();
        settle(1);
        check("dead_lives", 32'(lives), 0);
        check("dead_game_over", 32'(game_over), 1);
        do_reset();

        // Reset asserted in the fourth cooldown cycle.
        place(100, 100); sx[0] = 120; sy[0] = 110;
        do_frame();
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midcool_invincible", 32'(invincible), 0);
        check("midcool_lives", 32'(lives), LIVES);
        check("midcool_broken", 32'(broken), 0);
        lives_m = LIVES;
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        place(100, 100);
        apply();
        repeat (6) @(negedge clk);
        do_frame(); settle(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dt_slim_hit_scan.md
DT_SLIM_HIT_SCAN -- requirements
Module: dt_slim_hit_scan

Interface
REQ-001 SHALL have parameter N_SLIM, default 4: number of slime channels (>=1).
REQ-002 SHALL have parameter HALF_W, default 55: horizontal overlap half-extent, pixels.
REQ-003 SHALL have parameter HALF_H, default 38: vertical overlap half-extent, pixels.
REQ-004 SHALL have parameter INV_CYC, default 25000000: invincibility duration, clk cycles (>=1).
REQ-005 SHALL have parameter LIVES, default 3: initial life count (1..15).
REQ-006 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-008 SHALL have port frame_tick, input, 1: one-cycle scan request, once per frame.
REQ-009 SHALL have ports x_blue, input, 10 and y_blue, input, 9: player position.
REQ-010 SHALL have ports x_slim, input, 10*N_SLIM and y_slim, input, 9*N_SLIM: packed slime positions; slime k occupies bits [10k+9:10k] and [9k+8:9k].
REQ-011 SHALL have port isfrozen, input, N_SLIM: bit k high means slime k is frozen and harmless.
REQ-012 SHALL have port broken, output, 1: one-cycle pulse when a hit is registered.
REQ-013 SHALL have port hit_id, output, max(1,clog2(N_SLIM)): index of the slime that caused the last hit.
REQ-014 SHALL have port lives, output, 4: remaining lives.
REQ-015 SHALL have port invincible, output, 1: high during cooldown.
REQ-016 SHALL have port game_over, output, 1: sticky; high once lives reach 0.

Function
REQ-017 SHALL implement an FSM with states IDLE, SCAN, HIT, COOL and DEAD.
REQ-018 In IDLE, frame_tick=1 SHALL snapshot all position and isfrozen inputs, clear the scan index to 0 and enter SCAN.
REQ-019 SCAN SHALL test exactly one slime per cycle, in ascending index order, against the snapshot only.
REQ-020 The hit test for slime k SHALL be: not frozen, |x_blue-x_slim[k]| < HALF_W and |y_blue-y_slim[k]| < HALF_H.
REQ-021 The hit test SHALL be computed in widened (>=11-bit) unsigned arithmetic as a+H > b and b+H > a, so edge coordinates never wrap.
REQ-022 The first hitting index SHALL end the scan (lowest index wins) and enter HIT.
REQ-023 If no slime hits, the state SHALL return to IDLE after index N_SLIM-1 with no output change.
REQ-024 With frame_tick at cycle t and slime k hitting, broken SHALL be high for exactly cycle t+2+k.
REQ-025 In that same cycle, hit_id SHALL equal k and lives SHALL equal its previous value minus 1.
REQ-026 HIT SHALL last one cycle, then enter DEAD if lives is 0, otherwise enter COOL.
REQ-027 COOL SHALL hold invincible=1 for exactly INV_CYC cycles, then return to IDLE with invincible=0.
REQ-028 frame_tick SHALL be ignored in SCAN, HIT, COOL and DEAD; requests are not queued.
REQ-029 DEAD SHALL hold game_over=1, invincible=0 and broken=0 until reset; lives SHALL never underflow below 0.
REQ-030 hit_id SHALL hold its value until the next hit.
REQ-031 Input changes during SCAN SHALL NOT affect the current scan.

Reset
REQ-032 rst_n low SHALL immediately force IDLE, broken=0, hit_id=0, lives=LIVES, invincible=0, game_over=0, cooldown counter=0 and scan index=0, regardless of clk.
REQ-033 Reset asserted mid-SCAN or mid-COOL SHALL abort the operation; no broken pulse SHALL follow reset release without a new frame_tick.

Verification (N_SLIM=4, INV_CYC=8, LIVES=3)
REQ-034 Reset: rst_n=0 for 3 cycles -> broken=0, hit_id=0, lives=3, invincible=0, game_over=0.
REQ-035 Single hit: player (100,100), slime2 (150,130) unfrozen, others at (600,400); frame_tick at t -> broken pulse at t+4, hit_id=2, lives=2, invincible high for 8 cycles, then IDLE.
REQ-036 Boundaries: dx=55 -> no hit; dx=54 -> hit; dy=38 -> no hit; player (0,0) with slime0 (10,5) -> hit (no wrap); player (5,5) with slime0 (639,479) -> no hit.
REQ-037 Priority and freeze: slimes 1 and 3 overlap, slime0 overlaps but is frozen -> hit_id=1, broken at t+3; all overlapping slimes frozen -> no pulse.
REQ-038 Exhaustion: three hits separated by cooldown -> lives 3->2->1->0, game_over=1 after third; frame_tick during COOL and in DEAD -> no pulse, lives stays 0.
REQ-039 Reset mid-cooldown: rst_n low at cycle 4 of COOL -> invincible=0, lives=3 immediately; next frame_tick with no overlap -> no pulse.
